// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding,
// forwarding select codes, the hard-wired zero register and the
// forwarding priority helper.
package hazard_controller_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM result is younger than WB, so it wins; $0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_regwrite,
    input logic [4:0] wb_rd,
    input logic       wb_regwrite
  );
    if (mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == src))
      return FWD_MEM;
    else if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// EX-stage operand forwarding selects. Purely combinational, one lane per
// source operand; can be reused for ID-stage branch-compare forwarding.
module hazard_controller_forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [4:0] src_reg_num [2];
  logic [1:0] sel         [2];

  assign src_reg_num[0] = ex_rs;
  assign src_reg_num[1] = ex_rt;

  // One identical selector per operand lane.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign sel[gi] = fwd_select(src_reg_num[gi], mem_rd, mem_regwrite,
                                wb_rd, wb_regwrite);
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_controller.sv
// Pipeline interlock for the 5-stage MIPS core: load-use stall sequencing
// (LOAD_STALL_CYCLES bubbles per hazard), branch/jump redirect flushes and
// EX operand forwarding. Optional statistics counters are built only when
// HAZARD_STATS_EN is defined; otherwise the counter ports read zero.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_t  state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       lu_hit;
  logic       stall_raw, ifid_flush_raw, idex_flush_raw;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Load in EX whose destination is read by the instruction in ID.
  assign lu_hit = ex_memread && ex_regwrite && (ex_rd != REG_ZERO) &&
                  ((id_r1_used && (ex_rd == id_rs)) ||
                   (id_r2_used && (ex_rd == id_rt)));

  // Next-state and Mealy control outputs; redirect overrides everything.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    stall_raw      = 1'b0;
    ifid_flush_raw = 1'b0;
    idex_flush_raw = 1'b0;
    if (ex_redirect) begin
      ifid_flush_raw = 1'b1;
      idex_flush_raw = 1'b1;
      state_next     = ST_RUN;
      cnt_next       = 3'd0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (lu_hit) begin
            stall_raw      = 1'b1;
            idex_flush_raw = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = ST_LU_STALL;
              cnt_next   = STALL_RELOAD;
            end
          end
        end
        ST_LU_STALL: begin
          stall_raw      = 1'b1;
          idex_flush_raw = 1'b1;
          cnt_next       = cnt_reg - 3'd1;
          if (cnt_reg <= 3'd1) begin
            state_next = ST_RUN;
            cnt_next   = 3'd0;
          end
        end
        default: begin
          state_next = ST_RUN;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // State register with asynchronous reset back to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  hazard_controller_forward_unit u_forward_unit (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  // Outputs are forced low for as long as reset is held.
  assign pc_stall   = !rst && stall_raw;
  assign ifid_stall = !rst && stall_raw;
  assign ifid_flush = !rst && ifid_flush_raw;
  assign idex_flush = !rst && idex_flush_raw;
  assign fwd_a      = rst ? FWD_REG : fwd_a_raw;
  assign fwd_b      = rst ? FWD_REG : fwd_b_raw;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Free-running event counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall)    stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (ex_redirect) flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_events = flush_cnt_reg;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
